// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared types, header field positions and parity helper for the router receive port
package router_pkg;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PLD,
        PAR
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    function automatic logic [7:0] parity_next(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/router_rx_skid.sv
// rtl/router_rx_skid.sv - two-entry valid/ready payload buffer with occupancy output
module router_rx_skid
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       ready,
    output beat_t      beat,
    output logic       valid,
    output logic [1:0] count
);

    beat_t mem [2];
    logic  wr_ptr;
    logic  rd_ptr;
    logic  pop;

    assign valid = (count != 2'd0);
    assign pop   = valid && ready;
    // Head entry is only written when it is not the read slot, so it holds while stalled.
    assign beat  = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_beat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/router_rx_port.sv
// rtl/router_rx_port.sv - drains one router output port, strips header/parity and streams payload
module router_rx_port
    import router_pkg::*;
#(
    parameter logic [1:0] ADDR    = 2'd0,
    parameter int         TIMEOUT = 16,
    parameter int         CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             vld_in,
    input  logic [7:0]       data_in,
    output logic             read_enb,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_sop,
    output logic             m_eop,
    output logic             pkt_done,
    output logic             parity_err,
    output logic             addr_err,
    output logic [5:0]       pkt_len,
    output logic             pkt_abort,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t           state, state_nxt;
    logic             in_flight;
    logic [7:0]       acc;
    logic [LEN_W-1:0] rem, reads_left, hdr_len;
    logic [1:0]       hdr_addr;
    logic             first;
    beat_t            staged, skid_out;
    logic             staged_vld;
    logic [TMO_W-1:0] tmo_cnt;
    logic             push;
    logic [1:0]       skid_count;
    logic [2:0]       occupancy;
    logic             cap_pld, tmo_run, abort, done_evt, good_evt, bad_evt;

    // The newest payload byte waits in `staged` so an abort can still tag it EOP.
    assign occupancy = {1'b0, skid_count} + {2'b00, staged_vld} + {2'b00, in_flight};
    assign cap_pld   = in_flight && (state == PLD);
    assign tmo_run   = (state != IDLE) && !vld_in && !in_flight;
    assign abort     = tmo_run && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign push      = staged_vld && (cap_pld || state != PLD || staged.eop);
    assign good_evt  = done_evt && (data_in == acc) && (hdr_addr == ADDR);
    assign bad_evt   = (done_evt && !good_evt) || abort;

    always_comb begin
        state_nxt = state;
        read_enb  = 1'b0;
        done_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (vld_in && !in_flight) begin
                    read_enb  = 1'b1;
                    state_nxt = HDR;
                end
            end
            HDR: begin
                if (in_flight) begin
                    state_nxt = (data_in[LEN_MSB:LEN_LSB] == '0) ? PAR : PLD;
                end
            end
            PLD: begin
                read_enb = vld_in && (reads_left != '0) && (occupancy < 3'd2);
                if (in_flight && rem == LEN_W'(1)) begin
                    state_nxt = PAR;
                end
            end
            PAR: begin
                read_enb = vld_in && !in_flight;
                if (in_flight) begin
                    done_evt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
        endcase
        if (abort) begin
            state_nxt = IDLE;
            read_enb  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            in_flight  <= 1'b0;
            acc        <= 8'h00;
            rem        <= '0;
            reads_left <= '0;
            hdr_len    <= '0;
            hdr_addr   <= 2'b00;
            first      <= 1'b0;
            staged     <= '0;
            staged_vld <= 1'b0;
            tmo_cnt    <= '0;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            pkt_len    <= 6'd0;
            pkt_abort  <= 1'b0;
            pkt_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            in_flight  <= read_enb;
            pkt_done   <= done_evt;
            parity_err <= done_evt && (data_in != acc);
            addr_err   <= done_evt && (hdr_addr != ADDR);
            pkt_abort  <= abort;
            if (done_evt) begin
                pkt_len <= hdr_len;
            end
            if (in_flight || state == IDLE) begin
                tmo_cnt <= '0;
            end else if (tmo_run) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (state == HDR && in_flight) begin
                hdr_len    <= data_in[LEN_MSB:LEN_LSB];
                hdr_addr   <= data_in[ADDR_MSB:0];
                acc        <= data_in;
                rem        <= data_in[LEN_MSB:LEN_LSB];
                reads_left <= data_in[LEN_MSB:LEN_LSB];
                first      <= 1'b1;
            end
            if (state == PLD && read_enb) begin
                reads_left <= reads_left - LEN_W'(1);
            end
            if (push) begin
                staged_vld <= 1'b0;
            end
            if (cap_pld) begin
                acc        <= parity_next(acc, data_in);
                rem        <= rem - LEN_W'(1);
                first      <= 1'b0;
                staged     <= beat_t'{data: data_in, sop: first, eop: (rem == LEN_W'(1))};
                staged_vld <= 1'b1;
            end else if (abort && staged_vld) begin
                staged.eop <= 1'b1;
            end
            if (good_evt && pkt_cnt != {CNT_W{1'b1}}) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
            if (bad_evt && err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    router_rx_skid u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_beat (staged),
        .ready     (m_ready),
        .beat      (skid_out),
        .valid     (m_valid),
        .count     (skid_count)
    );

    assign m_data = skid_out.data;
    assign m_sop  = skid_out.sop;
    assign m_eop  = skid_out.eop;

endmodule

// File: tb/tb_router_rx_port.sv
// tb/tb_router_rx_port.sv - scoreboard bench for router_rx_port with a behavioural router port
module tb_router_rx_port;

    logic        clock = 1'b0;
    logic        reset, vld_in, read_enb, m_valid, m_ready, m_sop, m_eop;
    logic        pkt_done, parity_err, addr_err, pkt_abort;
    logic [7:0]  data_in, m_data;
    logic [5:0]  pkt_len;
    logic [15:0] pkt_cnt, err_cnt;

    int errors = 0;
    int checks = 0;
    int rd_count = 0;
    int abort_count = 0;
    logic       rd_req = 1'b0;
    logic [7:0] rq [$];
    logic [9:0] exp_beats [$];
    logic [7:0] exp_stat [$];

    router_rx_port #(.ADDR(2'd1), .TIMEOUT(16), .CNT_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .vld_in     (vld_in),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_sop      (m_sop),
        .m_eop      (m_eop),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .pkt_len    (pkt_len),
        .pkt_abort  (pkt_abort),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Router port: a read strobe seen in one cycle presents its byte during the next.
    always @(posedge clock) begin
        #1;
        if (reset) begin
            rq.delete();
            data_in = 8'h00;
        end else if (rd_req && rq.size() != 0) begin
            data_in = rq.pop_front();
        end
        vld_in = (rq.size() != 0);
    end

    always @(negedge clock) begin
        rd_req = read_enb && !reset;
        if (rd_req) rd_count++;
        if (!reset) begin
            if (m_valid && m_ready) begin
                if (exp_beats.size() == 0) check("extra_beat", 32'(m_valid), 32'd0);
                else check("beat", 32'({m_data, m_sop, m_eop}), 32'(exp_beats.pop_front()));
            end
            if (pkt_done) begin
                if (exp_stat.size() == 0) check("extra_done", 32'(pkt_done), 32'd0);
                else check("status", 32'({parity_err, addr_err, pkt_len}), 32'(exp_stat.pop_front()));
            end
            if (pkt_abort) abort_count++;
        end
    end

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl [$], input bit bad_par);
        logic [7:0] par = hdr;
        rq.push_back(hdr);
        foreach (pl[i]) begin
            rq.push_back(pl[i]);
            par ^= pl[i];
            exp_beats.push_back({pl[i], i == 0, i == pl.size() - 1});
        end
        rq.push_back(bad_par ? (par ^ 8'h01) : par);
        exp_stat.push_back({bad_par, hdr[1:0] != 2'd1, hdr[7:2]});
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_beats.size() != 0 || exp_stat.size() != 0) && n < 300) begin
            @(posedge clock);
            n++;
        end
        check(tag, 32'(exp_beats.size() + exp_stat.size()), 32'd0);
        repeat (3) @(posedge clock);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clock); #2;
        reset = 1'b1;
        exp_beats.delete();
        exp_stat.delete();
        @(posedge clock); #2;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] pl [$];
        logic [7:0] pl5 [$];
        int r0, a0, n;
        reset = 1'b1; vld_in = 1'b0; data_in = 8'h00; m_ready = 1'b1;
        pl  = '{8'h11, 8'h22, 8'h33};
        pl5 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        repeat (2) @(posedge clock);
        #2;
        check("rst_stream", 32'({m_valid, m_sop, m_eop, m_data}), 32'd0);
        check("rst_status", 32'({read_enb, pkt_done, parity_err, addr_err, pkt_abort, pkt_len}), 32'd0);
        check("rst_counters", {pkt_cnt, err_cnt}, 32'd0);
        reset = 1'b0;

        send_pkt(8'h0D, pl, 1'b0);
        wait_drain("good_drain");
        check("good_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("good_err_cnt", 32'(err_cnt), 32'd0);

        do_reset();
        send_pkt(8'h0D, pl, 1'b1);
        wait_drain("parity_drain");
        check("parity_err_cnt", 32'(err_cnt), 32'd1);
        check("parity_pkt_cnt", 32'(pkt_cnt), 32'd0);

        do_reset();
        send_pkt(8'h0E, pl, 1'b0);
        wait_drain("addr_drain");
        check("addr_err_cnt", 32'(err_cnt), 32'd1);

        do_reset();
        m_ready = 1'b0;
        r0 = rd_count;
        send_pkt(8'h15, pl5, 1'b0);
        repeat (20) @(posedge clock);
        #2;
        check("stall_reads", 32'(rd_count - r0), 32'd3);
        check("stall_read_enb", 32'(read_enb), 32'd0);
        check("stall_head", 32'({m_valid, m_data, m_sop}), 32'({1'b1, 8'hA1, 1'b1}));
        m_ready = 1'b1;
        wait_drain("stall_drain");
        check("stall_pkt_cnt", 32'(pkt_cnt), 32'd1);

        do_reset();
        pl.delete();
        send_pkt(8'h01, pl, 1'b0);
        wait_drain("empty_drain");
        check("empty_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("empty_err_cnt", 32'(err_cnt), 32'd0);

        do_reset();
        a0 = abort_count;
        rq.push_back(8'h0D);
        rq.push_back(8'h11);
        exp_beats.push_back({8'h11, 1'b1, 1'b1});
        repeat (10) @(posedge clock);
        #2;
        check("abort_early", 32'(abort_count - a0), 32'd0);
        wait_drain("abort_drain");
        check("abort_pulses", 32'(abort_count - a0), 32'd1);
        check("abort_err_cnt", 32'(err_cnt), 32'd1);
        pl = '{8'h11, 8'h22, 8'h33};
        send_pkt(8'h0D, pl, 1'b0);
        wait_drain("after_abort_drain");
        check("after_abort_cnts", {pkt_cnt, err_cnt}, {16'd1, 16'd1});

        do_reset();
        send_pkt(8'h15, pl5, 1'b0);
        n = 0;
        while (exp_beats.size() > 3 && n < 100) begin
            @(posedge clock);
            n++;
        end
        check("mid_pkt_reached", 32'(exp_beats.size()), 32'd3);
        #2;
        reset = 1'b1;
        exp_beats.delete();
        exp_stat.delete();
        @(posedge clock); #2;
        check("midrst_stream", 32'({m_valid, m_sop, m_eop, m_data}), 32'd0);
        check("midrst_status", 32'({read_enb, pkt_done, parity_err, addr_err, pkt_abort, pkt_len}), 32'd0);
        reset = 1'b0;
        send_pkt(8'h0D, pl, 1'b0);
        wait_drain("midrst_drain");
        check("midrst_pkt_cnt", 32'(pkt_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_rx_port.md
Name: router_rx_port

Overview:
- Downstream consumer for one router output port: drains `vld_out_N`/`data_out_N` by driving `read_enb_N`.
- Strips the header and parity bytes and forwards payload as a valid/ready byte stream with SOP/EOP.
- Checks packet parity and reports per-packet status plus saturating statistics.
- One instance per port (0..2) in the system-level wrapper around the router.

Parameters:
- ADDR, 2'd0, port address this instance serves; header addr field must match.
- TIMEOUT, 16, max cycles `vld_in` may stay low mid-packet before abort.
- CNT_W, 16, width of statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- vld_in  in  1  router port vld_out (FIFO not empty).
- data_in  in  8  router port data_out; valid the cycle after `read_enb` sampled high.
- read_enb  out  1  read strobe to router port.
- m_data  out  8  payload byte.
- m_valid  out  1  payload byte valid.
- m_ready  in  1  sink accepts byte when `m_valid && m_ready`.
- m_sop  out  1  first payload byte of packet.
- m_eop  out  1  last payload byte of packet.
- pkt_done  out  1  one-cycle pulse when the parity byte has been checked.
- parity_err  out  1  valid with `pkt_done`; computed parity != received parity.
- addr_err  out  1  valid with `pkt_done`; header addr != ADDR.
- pkt_len  out  6  header length field of the last completed packet.
- pkt_abort  out  1  one-cycle pulse on timeout abort.
- pkt_cnt  out  CNT_W  good packets (saturating).
- err_cnt  out  CNT_W  parity/addr errors plus aborts (saturating).

Behaviour:
- Packet format:
  - Header byte: [7:2] = length L, [1:0] = addr.
  - L payload bytes follow.
  - Parity byte = XOR of header and all payload bytes.
- Reset: all outputs 0, FSM in IDLE, skid buffer empty, counters 0.
- Read latency: `data_in` is captured exactly one cycle after a cycle with `read_enb=1`. An in-flight flag tracks this.
- `read_enb` is asserted only when all of the following hold:
  - `vld_in=1`;
  - state is not IDLE-with-capture-pending;
  - for payload reads, buffer occupancy + in-flight < 2.
- The parity read and the header read need no buffer space.
- FSM states:
  - IDLE: `vld_in` → assert `read_enb`, go HDR.
  - HDR: capture header into `hdr_reg`, parity acc = header, remaining = L. If L==0, go PAR; else go PLD.
  - PLD: each captured byte is pushed to the skid buffer and XORed into acc; remaining decrements. The first byte is tagged SOP and the byte with remaining==1 is tagged EOP. When remaining reaches 0, go PAR.
  - PAR: capture parity byte, compare with acc. Pulse `pkt_done`, `parity_err`, `addr_err`; latch `pkt_len`. Go IDLE.
- L==0 is a legal empty packet: no stream output, `pkt_done` still pulses.
- An addr mismatch still forwards the payload; it is flagged only.
- Timeout:
  - In HDR/PLD/PAR, a counter runs while `vld_in=0` and no byte is in flight. It clears whenever a byte is captured.
  - When the count reaches TIMEOUT: pulse `pkt_abort`, drop the remaining count, go IDLE.
  - If a payload was partially output, the next byte pushed is force-tagged EOP (an abort marker is not required). Otherwise nothing is emitted.
- Skid buffer: 2 entries of {data, sop, eop}. `m_valid` = not empty. It is never overrun because of the `read_enb` credit rule. `m_data`/`m_sop`/`m_eop` stay stable while `m_valid && !m_ready`.
- Counters:
  - `pkt_cnt` increments on `pkt_done` with no errors.
  - `err_cnt` increments on `pkt_done` with any error, and on `pkt_abort`.
  - Both saturate at all-ones.
- Simultaneous push and pop on the skid buffer in one cycle keeps occupancy unchanged.
- Reset mid-packet:
  - Immediate return to IDLE, buffer flushed, no `pkt_done`.
  - The router-side byte in flight is discarded.

Decomposition:
- Shared package `router_pkg`:
  - header field positions (LEN_MSB=7, LEN_LSB=2, ADDR_MSB=1);
  - state enum {IDLE, HDR, PLD, PAR};
  - parity function.
- Sub-module `router_rx_skid`: 2-entry valid/ready buffer with push, count, and occupancy output.

Test Plan:
- ADDR=1, header 0x0D, payload 0x11 0x22 0x33, parity 0x0D, `m_ready=1`:
  - `m_data` = 11(sop), 22, 33(eop);
  - `pkt_done`=1, `parity_err`=0, `pkt_len`=3, `pkt_cnt`=1.
- Same packet with parity 0x0C → `pkt_done` with `parity_err`=1, `err_cnt`=1, payload still streamed.
- `m_ready` held 0 with 5-byte payload available:
  - at most 2 payload reads issued, then `read_enb`=0;
  - releasing `m_ready` drains all 5 bytes in order.
- Header 0x01 (L=0, addr 1) + parity 0x01 → no `m_valid`, `pkt_done`=1, no errors.
- Header 0x0D, one payload byte, then `vld_in`=0 for 16 cycles → `pkt_abort` pulse, byte 0x11 emitted with sop+eop, `err_cnt`=1, back to IDLE.
- `reset` asserted in PLD → next cycle all outputs 0; a subsequent good packet is received correctly.
